alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports i_in_valid input 1 and o_in_ready output 1, the upstream valid/ready handshake.
REQ-005 SHALL have ports i_opcode input 7, i_funct3 input 3 and i_funct7 input 7, the RV32I instruction fields.
REQ-006 SHALL have port i_rd  input  5  destination register index.
REQ-007 SHALL have ports i_rs1_data, i_rs2_data, i_imm and i_pc, each input XLEN, the operand sources.
REQ-008 SHALL have ports o_op_a output XLEN, o_op_b output XLEN and o_alu_op output 4, which drive the ALU operand and opcode inputs.
REQ-009 SHALL have port i_alu_data  input  XLEN  combinational ALU result for the current o_op_a/o_op_b/o_alu_op.
REQ-010 SHALL have ports o_wb_valid output 1 and i_wb_ready input 1, the downstream valid/ready handshake.
REQ-011 SHALL have ports o_wb_data output XLEN, o_wb_rd output 5 and o_wb_illegal output 1, the writeback payload.

Function
REQ-012 SHALL encode o_alu_op as ADD 0000, SUB 0001, SLT 0010, SLTU 0011, SLL 0100, SRL 0101, SRA 0110, XOR 1000, OR 1001, AND 1010.
REQ-013 SHALL decode OP (0110011) and OP-IMM (0010011) by funct3 as follows: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-014 SHALL select SUB only for OP with funct7=0100000, and SRA for funct3=101 with funct7=0100000 (OP or OP-IMM).
REQ-015 SHALL flag as illegal: funct7 not in {0000000, 0100000} for OP; funct7=0100000 on an OP funct3 other than 000/101; funct7 not 0000000 on OP-IMM 001; funct7 not in {0000000, 0100000} on OP-IMM 101; any other opcode.
REQ-016 SHALL set operands as follows: OP: a=rs1, b=rs2; OP-IMM: a=rs1, b=i_imm.
REQ-017 SHALL, for an illegal entry, force a=0, b=0, op=ADD and carry illegal=1.
REQ-018 SHALL be a two-stage pipeline: E register (e_valid, o_op_a, o_op_b, o_alu_op, rd, illegal) then W register (o_wb_valid, o_wb_data, o_wb_rd, o_wb_illegal).
REQ-019 SHALL compute w_free = !o_wb_valid || i_wb_ready and o_in_ready = !e_valid || w_free, combinationally.
REQ-020 SHALL load E on i_in_valid && o_in_ready, and clear e_valid when E advances without a new load.
REQ-021 SHALL, when e_valid && w_free, load W with o_wb_data=i_alu_data and copy rd/illegal from E; o_wb_valid becomes 1.
REQ-022 SHALL clear o_wb_valid when i_wb_ready=1 and there is no E advance.
REQ-023 SHALL make o_wb_valid rise on the second rising edge after acceptance with no stall, giving sustained throughput of 1 per cycle.
REQ-024 SHALL hold E and W payloads stable while stalled, and SHALL NOT change ALU ports while e_valid && !w_free.
REQ-025 SHALL process a simultaneous accept, advance and drain in the same cycle without bubble or loss.

Reset
REQ-026 SHALL, on i_rst, immediately clear e_valid, o_wb_valid, o_op_a, o_op_b, o_alu_op, o_wb_data, o_wb_rd and o_wb_illegal to 0.
REQ-027 SHALL discard in-flight entries on reset mid-operation; no result for them ever appears.
REQ-028 SHALL have o_in_ready=1 on the first cycle after reset release.

Configuration
REQ-029 SHALL, with ALU_ISSUE_UTYPE_EN defined, decode LUI (0110111) as a=0, b=imm, ADD and AUIPC (0010111) as a=i_pc, b=imm, ADD; without the macro both opcodes SHALL be illegal per REQ-017.

Verification
REQ-030 SHALL cover: OP ADD with rs1=5, rs2=7 and the ALU model attached -> o_wb_data=12, illegal=0, o_wb_valid rises on the second edge after accept.
REQ-031 SHALL cover: OP funct7=0100000, funct3=101, rs1=0x80000000, rs2=4 -> o_alu_op=0110, o_wb_data=0xF8000000.
REQ-032 SHALL cover: back-to-back stream of 4 items with i_wb_ready held 0 -> o_in_ready falls after 2 accepts; then release -> all 4 results appear in order with no loss.
REQ-033 SHALL cover: OP-IMM funct3=001, funct7=0100000 -> o_wb_illegal=1, o_wb_data=0.
REQ-034 SHALL cover: AUIPC with pc=0x100, imm=0x2000 -> 0x2100 with the macro defined, illegal=1 without it.
REQ-035 SHALL cover: i_rst asserted with both stages full -> o_wb_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: RV32I OP / OP-IMM issue stage with a two-entry (E, W) pipeline.
// E decodes the instruction and drives an external combinational ALU.
// W captures the ALU result and offers it downstream through valid/ready.
// Optional feature: define ALU_ISSUE_UTYPE_EN to also issue LUI and AUIPC as ADDs.
// Without that macro, LUI and AUIPC are treated as illegal.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [6:0]      i_funct7,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_op_a,
    output logic [XLEN-1:0] o_op_b,
    output logic [3:0]      o_alu_op,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_wb_valid,
    input  logic            i_wb_ready,
    output logic [XLEN-1:0] o_wb_data,
    output logic [4:0]      o_wb_rd,
    output logic            o_wb_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_AND  = 4'b1010;

    logic            r_e_valid;
    logic [4:0]      r_e_rd;
    logic            r_e_illegal;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [3:0]      r_alu_op;
    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_data;
    logic [4:0]      r_wb_rd;
    logic            r_wb_illegal;

    logic            w_free;
    logic            w_accept;
    logic            w_advance;
    logic [XLEN-1:0] w_dec_a;
    logic [XLEN-1:0] w_dec_b;
    logic [3:0]      w_dec_op;
    logic            w_dec_ill;
    logic [3:0]      w_f3_op;

`ifndef ALU_ISSUE_UTYPE_EN
    // i_pc only feeds AUIPC, which does not exist in this build.
    logic w_unused_pc;
    assign w_unused_pc = ^i_pc;
`endif

    // W can take a new result when it is empty or is draining this cycle.
    assign w_free     = !r_wb_valid || i_wb_ready;
    assign o_in_ready = !r_e_valid || w_free;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_advance  = r_e_valid && w_free;

    assign o_op_a       = r_op_a;
    assign o_op_b       = r_op_b;
    assign o_alu_op     = r_alu_op;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_data    = r_wb_data;
    assign o_wb_rd      = r_wb_rd;
    assign o_wb_illegal = r_wb_illegal;

    // Map funct3 to the ALU code, assuming funct7 picks the base variant.
    always_comb begin
        w_f3_op = ALU_ADD;
        case (i_funct3)
            3'b000:  w_f3_op = ALU_ADD;
            3'b001:  w_f3_op = ALU_SLL;
            3'b010:  w_f3_op = ALU_SLT;
            3'b011:  w_f3_op = ALU_SLTU;
            3'b100:  w_f3_op = ALU_XOR;
            3'b101:  w_f3_op = ALU_SRL;
            3'b110:  w_f3_op = ALU_OR;
            default: w_f3_op = ALU_AND;
        endcase
    end

    // Decode the operand sources, ALU op and legality of the incoming instruction.
    always_comb begin
        w_dec_a   = i_rs1_data;
        w_dec_b   = i_rs2_data;
        w_dec_op  = w_f3_op;
        w_dec_ill = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                if (i_funct7 == F7_ALT) begin
                    if (i_funct3 == 3'b000)      w_dec_op  = ALU_SUB;
                    else if (i_funct3 == 3'b101) w_dec_op  = ALU_SRA;
                    else                         w_dec_ill = 1'b1;
                end else if (i_funct7 != F7_ZERO) begin
                    w_dec_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                w_dec_b = i_imm;
                // Only the shift forms reserve funct7; elsewhere it is immediate bits.
                if (i_funct3 == 3'b001 && i_funct7 != F7_ZERO) begin
                    w_dec_ill = 1'b1;
                end else if (i_funct3 == 3'b101) begin
                    if (i_funct7 == F7_ALT)       w_dec_op  = ALU_SRA;
                    else if (i_funct7 != F7_ZERO) w_dec_ill = 1'b1;
                end
            end
`ifdef ALU_ISSUE_UTYPE_EN
            OPC_LUI: begin
                w_dec_a  = '0;
                w_dec_b  = i_imm;
                w_dec_op = ALU_ADD;
            end
            OPC_AUIPC: begin
                w_dec_a  = i_pc;
                w_dec_b  = i_imm;
                w_dec_op = ALU_ADD;
            end
`endif
            default: w_dec_ill = 1'b1;
        endcase
        // Illegal entries still flow through as a harmless 0+0.
        if (w_dec_ill) begin
            w_dec_a  = '0;
            w_dec_b  = '0;
            w_dec_op = ALU_ADD;
        end
    end

    // E stage: capture the decoded entry on accept and empty when it moves on without a refill.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_e_valid   <= 1'b0;
            r_e_rd      <= '0;
            r_e_illegal <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_alu_op    <= ALU_ADD;
        end else if (w_accept) begin
            r_e_valid   <= 1'b1;
            r_e_rd      <= i_rd;
            r_e_illegal <= w_dec_ill;
            r_op_a      <= w_dec_a;
            r_op_b      <= w_dec_b;
            r_alu_op    <= w_dec_op;
        end else if (w_advance) begin
            r_e_valid   <= 1'b0;
        end
    end

    // W stage: capture the ALU result as E advances and empty on a drain without a refill.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_rd      <= '0;
            r_wb_illegal <= 1'b0;
        end else if (w_advance) begin
            r_wb_valid   <= 1'b1;
            r_wb_data    <= i_alu_data;
            r_wb_rd      <= r_e_rd;
            r_wb_illegal <= r_e_illegal;
        end else if (i_wb_ready) begin
            r_wb_valid   <= 1'b0;
        end
    end

endmodule
